// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between execute and a 64-bit data memory.
//
// Accepts byte/half/word/doubleword loads and stores over a valid/ready
// handshake, converts byte addresses to doubleword indices, performs
// read-modify-write for sub-doubleword stores and lane extraction with
// sign/zero extension for loads.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// (one-cycle resp_valid_o + resp_fault_o, no memory strobes). Without it,
// resp_fault_o is tied 0 and low offset bits below the access size are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only when idle)
//   req_we_i, req_size_i       store flag, size (00 B, 01 H, 10 W, 11 D)
//   req_unsigned_i             zero-extend load result
//   req_addr_i, req_wdata_i    byte address, right-justified store data
//   resp_valid_o               one-cycle completion pulse
//   resp_rdata_o               extended load data (0 for stores), held
//   resp_fault_o               misaligned-access trap
//   mem_addr_o                 doubleword index (0 when idle)
//   mem_wdata_o, mem_write_o   write data / strobe
//   mem_read_o, mem_rdata_i    read strobe / data (valid cycle after read)
module lsu_mem_port #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned IDX_SHIFT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_fault_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            mem_write_o,
    output logic            mem_read_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        StIdle, StLdRd, StLdRsp, StStWr, StRmwRd, StRmwWr, StDone, StFault
    } state_e;

    state_e state_q, state_d;

    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            accept;
    logic            misalign;
    logic [2:0]      off;
    logic [5:0]      shamt;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] merged;

    assign accept = req_valid_i && (state_q == StIdle);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        unique case (req_size_i)
            2'b01:   misalign = req_addr_i[0];
            2'b10:   misalign = |req_addr_i[1:0];
            2'b11:   misalign = |req_addr_i[2:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Request latch and held response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (misalign)                state_d = StFault;
                    else if (!req_we_i)          state_d = StLdRd;
                    else if (req_size_i == 2'b11) state_d = StStWr;
                    else                         state_d = StRmwRd;
                end
            end
            StLdRd:  state_d = StLdRsp;
            StLdRsp: state_d = StIdle;
            StStWr:  state_d = StDone;
            StRmwRd: state_d = StRmwWr;
            StRmwWr: state_d = StDone;
            StDone:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane offset: bits below the access size are ignored (forced alignment).
    always_comb begin
        unique case (size_q)
            2'b00:   begin off = addr_q[2:0];          lane_mask = XLEN'(8'hFF);        end
            2'b01:   begin off = {addr_q[2:1], 1'b0};  lane_mask = XLEN'(16'hFFFF);     end
            2'b10:   begin off = {addr_q[2], 2'b00};   lane_mask = XLEN'(32'hFFFF_FFFF); end
            default: begin off = 3'd0;                 lane_mask = '1;                  end
        endcase
    end

    assign shamt  = {off, 3'b000};
    assign lane   = mem_rdata_i >> shamt;
    assign merged = (mem_rdata_i & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    always_comb begin
        unique case (size_q)
            2'b00:   ld_ext = uns_q ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                    : {{(XLEN-8){lane[7]}}, lane[7:0]};
            2'b01:   ld_ext = uns_q ? {{(XLEN-16){1'b0}}, lane[15:0]}
                                    : {{(XLEN-16){lane[15]}}, lane[15:0]};
            2'b10:   ld_ext = uns_q ? {{(XLEN-32){1'b0}}, lane[31:0]}
                                    : {{(XLEN-32){lane[31]}}, lane[31:0]};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    // Output logic, decoded from state
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        mem_read_o   = (state_q == StLdRd) || (state_q == StRmwRd);
        mem_write_o  = (state_q == StStWr) || (state_q == StRmwWr);
        resp_valid_o = (state_q == StLdRsp) || (state_q == StDone) || (state_q == StFault);
`ifdef LSU_MISALIGN_TRAP_EN
        resp_fault_o = (state_q == StFault);
`else
        resp_fault_o = 1'b0;
`endif
        mem_addr_o   = (state_q == StIdle) ? '0 : (addr_q >> IDX_SHIFT);
        mem_wdata_o  = '0;
        if (state_q == StStWr)  mem_wdata_o = wdata_q;
        if (state_q == StRmwWr) mem_wdata_o = merged;
        // Stores and faults report 0; the register then holds that until the next response.
        rdata_d      = rdata_q;
        resp_rdata_o = rdata_q;
        if (state_q == StLdRsp) begin
            rdata_d      = ld_ext;
            resp_rdata_o = ld_ext;
        end else if (state_q == StDone || state_q == StFault) begin
            rdata_d      = '0;
            resp_rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;
    int both_strobes = 0;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_fault_o   (resp_fault),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_write_o    (mem_write),
        .mem_read_o     (mem_read),
        .mem_rdata_i    (mem_rdata)
    );

    // Synchronous-read memory model, preloaded with mem[i] = i.
    logic [63:0] mem [16];
    bit preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'(i);
            preloaded <= 1'b1;
        end else begin
            if (mem_read)  mem_rdata <= mem[mem_addr[3:0]];
            if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) if (mem_read && mem_write) both_strobes++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp; // load result or written doubleword
    } vec_t;

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        chk("ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        // Fields are latched at acceptance; scramble them afterwards.
        req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
        req_addr = 64'hDEAD_BEEF_0000_0007; req_wdata = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk); // T+1
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] idx;
        idx = {3'b000, v.addr[63:3]};
        issue(v.we, v.size, v.uns, v.addr, v.wdata);
        if (!v.we || v.size != 2'b11) begin
            chk({v.name, ":rd_t1"},   {63'd0, mem_read},  64'd1);
            chk({v.name, ":wr_t1"},   {63'd0, mem_write}, 64'd0);
        end else begin
            chk({v.name, ":rd_t1"},   {63'd0, mem_read},  64'd0);
            chk({v.name, ":wr_t1"},   {63'd0, mem_write}, 64'd1);
            chk({v.name, ":wdata"},   mem_wdata, v.exp);
        end
        chk({v.name, ":addr_t1"},  mem_addr, idx);
        chk({v.name, ":rv_t1"},    {63'd0, resp_valid}, 64'd0);
        chk({v.name, ":rdy_t1"},   {63'd0, req_ready}, 64'd0);
        @(negedge clk); // T+2
        if (v.we && v.size != 2'b11) begin
            chk({v.name, ":wr_t2"},  {63'd0, mem_write}, 64'd1);
            chk({v.name, ":rd_t2"},  {63'd0, mem_read},  64'd0);
            chk({v.name, ":wdata"},  mem_wdata, v.exp);
            chk({v.name, ":rv_t2"},  {63'd0, resp_valid}, 64'd0);
            @(negedge clk); // T+3
        end
        chk({v.name, ":resp_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({v.name, ":resp_fault"}, {63'd0, resp_fault}, 64'd0);
        chk({v.name, ":strobes_rsp"}, {62'd0, mem_read, mem_write}, 64'd0);
        chk({v.name, ":resp_rdata"}, resp_rdata, v.we ? 64'd0 : v.exp);
        @(negedge clk);
        chk({v.name, ":rv_drop"}, {63'd0, resp_valid}, 64'd0);
        chk({v.name, ":rdata_hold"}, resp_rdata, v.we ? 64'd0 : v.exp);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"LD_28",  1'b0, 2'b11, 1'b0, 64'h28, 64'h0, 64'h5});
        vecs.push_back('{"SD_40",  1'b1, 2'b11, 1'b0, 64'h40, 64'hFFEEDDCCBBAA9988,
                         64'hFFEEDDCCBBAA9988});
        vecs.push_back('{"LB_41",  1'b0, 2'b00, 1'b0, 64'h41, 64'h0, 64'hFFFFFFFFFFFFFF99});
        vecs.push_back('{"LBU_41", 1'b0, 2'b00, 1'b1, 64'h41, 64'h0, 64'h99});
        vecs.push_back('{"LH_46",  1'b0, 2'b01, 1'b0, 64'h46, 64'h0, 64'hFFFFFFFFFFFFFFEE});
        vecs.push_back('{"LW_44",  1'b0, 2'b10, 1'b0, 64'h44, 64'h0, 64'hFFFFFFFFFFEEDDCC});
        vecs.push_back('{"LWU_44", 1'b0, 2'b10, 1'b1, 64'h44, 64'h0, 64'h00000000FFEEDDCC});
        vecs.push_back('{"SB_42",  1'b1, 2'b00, 1'b0, 64'h42, 64'h11, 64'hFFEEDDCCBB119988});
        vecs.push_back('{"LD_40a", 1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'hFFEEDDCCBB119988});
        vecs.push_back('{"LHU_40", 1'b0, 2'b01, 1'b1, 64'h40, 64'h0, 64'h9988});
        vecs.push_back('{"LH_42",  1'b0, 2'b01, 1'b0, 64'h42, 64'h0, 64'hFFFFFFFFFFFFBB11});
        vecs.push_back('{"SW_44",  1'b1, 2'b10, 1'b0, 64'h44, 64'hCAFE_0000_1234_5678,
                         64'h12345678BB119988});
        vecs.push_back('{"SH_46",  1'b1, 2'b01, 1'b0, 64'h46, 64'h0000_0000_0000_ABCD,
                         64'hABCD5678BB119988});
        vecs.push_back('{"LD_40b", 1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'hABCD5678BB119988});
        vecs.push_back('{"LB_47",  1'b0, 2'b00, 1'b0, 64'h47, 64'h0, 64'hFFFFFFFFFFFFFFAB});
        vecs.push_back('{"LBU_40", 1'b0, 2'b00, 1'b1, 64'h40, 64'h0, 64'h88});
        vecs.push_back('{"SD_18",  1'b1, 2'b11, 1'b0, 64'h18, 64'h0123456789ABCDEF,
                         64'h0123456789ABCDEF});
        vecs.push_back('{"LD_18",  1'b0, 2'b11, 1'b0, 64'h18, 64'h0, 64'h0123456789ABCDEF});
`ifndef LSU_MISALIGN_TRAP_EN
        // Forced alignment: LW 0x42 reads the word lane at 0x40.
        vecs.push_back('{"LW_42",  1'b0, 2'b10, 1'b0, 64'h42, 64'h0, 64'hFFFFFFFFBB119988});
`endif

        // Reset state
        #2;
        chk("rst:mem_read",   {63'd0, mem_read},   64'd0);
        chk("rst:mem_write",  {63'd0, mem_write},  64'd0);
        chk("rst:resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst:resp_rdata", resp_rdata, 64'd0);
        chk("rst:mem_addr",   mem_addr, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst:ready", {63'd0, req_ready}, 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word: one-cycle fault response, no strobes.
        issue(1'b0, 2'b10, 1'b0, 64'h42, 64'h0);
        chk("flt:resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("flt:resp_fault", {63'd0, resp_fault}, 64'd1);
        chk("flt:strobes",    {62'd0, mem_read, mem_write}, 64'd0);
        chk("flt:resp_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        chk("flt:ready",      {63'd0, req_ready}, 64'd1);
        chk("flt:fault_drop", {63'd0, resp_fault}, 64'd0);
        chk("flt:strobes2",   {62'd0, mem_read, mem_write}, 64'd0);
`endif

        // Reset cut during RMW_RD of SH 0x40: no write may land.
        issue(1'b1, 2'b01, 1'b0, 64'h40, 64'h7777);
        chk("rstcut:rd_t1", {63'd0, mem_read}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstcut:rd_drop",  {63'd0, mem_read},   64'd0);
        chk("rstcut:wr",       {63'd0, mem_write},  64'd0);
        chk("rstcut:rv",       {63'd0, resp_valid}, 64'd0);
        chk("rstcut:rdata",    resp_rdata, 64'd0);
        @(negedge clk);
        chk("rstcut:wr_hold",  {63'd0, mem_write},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstcut:ready",    {63'd0, req_ready}, 64'd1);
        chk("rstcut:wr_after", {63'd0, mem_write}, 64'd0);
        run_vec('{"LD_40_post_rst", 1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 64'hABCD5678BB119988});

        chk("never_both_strobes", 64'(both_strobes), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
